// File: rtl/line_pkg.sv
// Shared types and constants for the front-of-line grant controller.
// Used by line_order_fifo and line_grant_ctrl (optional stats: LINE_STATS_EN).
package line_pkg;

  localparam int NUM_CHILD   = 4;
  localparam int QUEUE_DEPTH = 4;
  localparam int SERVICE_W   = 8;
  localparam int COUNT_W     = 3;

  typedef logic [1:0] child_idx_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SERVE = 2'd1,
    DONE  = 2'd2
  } line_state_t;

  function automatic logic [NUM_CHILD-1:0] child_onehot(input child_idx_t idx);
    logic [NUM_CHILD-1:0] vec;
    vec      = '0;
    vec[idx] = 1'b1;
    return vec;
  endfunction

endpackage

// File: rtl/line_order_fifo.sv
// Arrival-order queue of child indices: multi-push in ascending index order,
// single pop from the head, with occupancy count and membership bitmap.
module line_order_fifo
  import line_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_CHILD-1:0] push,
  input  logic                 pop,
  output child_idx_t           head,
  output logic [COUNT_W-1:0]   count,
  output logic [NUM_CHILD-1:0] member
);

  child_idx_t               slot_reg  [QUEUE_DEPTH];
  child_idx_t               slot_next [QUEUE_DEPTH];
  logic [COUNT_W-1:0]       count_reg, count_next;
  logic [NUM_CHILD-1:0]     member_reg, member_next;
  logic                     do_pop;

  assign do_pop = pop && (count_reg != '0);

  always_comb begin
    slot_next   = slot_reg;
    count_next  = count_reg;
    member_next = member_reg;

    if (do_pop) begin
      for (int i = 0; i < QUEUE_DEPTH - 1; i++) begin
        slot_next[i] = slot_reg[i+1];
      end
      count_next              = count_reg - COUNT_W'(1);
      member_next[slot_reg[0]] = 1'b0;
    end

    // Pushes land after the popped entry has left, lowest index first.
    for (int i = 0; i < NUM_CHILD; i++) begin
      if (push[i] && (count_next < COUNT_W'(QUEUE_DEPTH))) begin
        slot_next[count_next[1:0]] = child_idx_t'(i);
        count_next                 = count_next + COUNT_W'(1);
        member_next[i]             = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        slot_reg[i] <= '0;
      end
      count_reg  <= '0;
      member_reg <= '0;
    end else begin
      slot_reg   <= slot_next;
      count_reg  <= count_next;
      member_reg <= member_next;
    end
  end

  assign head   = slot_reg[0];
  assign count  = count_reg;
  assign member = member_reg;

endmodule

// File: rtl/line_grant_ctrl.sv
// Arrival-order scheduler granting one shared resource to one of four children
// for SERVICE_FRAMES frames. Define LINE_STATS_EN to add the served_cnt counter.
module line_grant_ctrl
  import line_pkg::*;
#(
  parameter int SERVICE_FRAMES = 60
) (
  input  logic                 Clk,
  input  logic                 Reset_n,
  input  logic                 frame_tick,
  input  logic [NUM_CHILD-1:0] req,
  output logic [NUM_CHILD-1:0] grant,
  output logic [NUM_CHILD-1:0] stop,
  output logic                 busy,
  output logic                 done
`ifdef LINE_STATS_EN
  ,
  output logic [SERVICE_W-1:0] served_cnt
`endif
);

  if ((SERVICE_FRAMES < 1) || (SERVICE_FRAMES > 255)) begin : g_bad_service_frames
    $error("line_grant_ctrl: SERVICE_FRAMES must be in 1..255");
  end

  localparam logic [SERVICE_W-1:0] SERVICE_LOAD = SERVICE_W'(SERVICE_FRAMES);

  logic [NUM_CHILD-1:0] req_q_reg;
  logic [NUM_CHILD-1:0] rise;
  logic [NUM_CHILD-1:0] push;
  logic [NUM_CHILD-1:0] queued;
  logic                 pop;
  child_idx_t           q_head;
  logic [COUNT_W-1:0]   q_count;

  line_state_t          state_reg, state_next;
  logic [NUM_CHILD-1:0] grant_reg, grant_next;
  child_idx_t           head_reg, head_next;
  logic [SERVICE_W-1:0] cnt_reg, cnt_next;
  logic                 done_reg, done_next;
  logic                 busy_reg;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      req_q_reg <= '0;
    end else begin
      req_q_reg <= req;
    end
  end

  // A child already waiting or being served never gets a second queue slot.
  for (genvar gi = 0; gi < NUM_CHILD; gi++) begin : g_push
    assign rise[gi] = req[gi] & ~req_q_reg[gi];
    assign push[gi] = rise[gi] & ~queued[gi] & ~grant_reg[gi];
  end

  line_order_fifo u_order (
    .clk    (Clk),
    .rst_n  (Reset_n),
    .push   (push),
    .pop    (pop),
    .head   (q_head),
    .count  (q_count),
    .member (queued)
  );

  always_comb begin
    state_next = state_reg;
    grant_next = grant_reg;
    head_next  = head_reg;
    cnt_next   = cnt_reg;
    done_next  = 1'b0;
    pop        = 1'b0;

    unique case (state_reg)
      IDLE: begin
        if (q_count != '0) begin
          pop = 1'b1;
          // A head whose request has gone away is dropped without service.
          if (req[q_head]) begin
            grant_next = child_onehot(q_head);
            head_next  = q_head;
            cnt_next   = SERVICE_LOAD;
            state_next = SERVE;
          end
        end
      end
      SERVE: begin
        if (frame_tick) begin
          cnt_next = cnt_reg - SERVICE_W'(1);
        end
        if (!req[head_reg] || (frame_tick && (cnt_reg == SERVICE_W'(1)))) begin
          grant_next = '0;
          done_next  = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        grant_next = '0;
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_reg <= IDLE;
      grant_reg <= '0;
      head_reg  <= '0;
      cnt_reg   <= '0;
      done_reg  <= 1'b0;
      busy_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      grant_reg <= grant_next;
      head_reg  <= head_next;
      cnt_reg   <= cnt_next;
      done_reg  <= done_next;
      busy_reg  <= (grant_next != '0);
    end
  end

  assign grant = grant_reg;
  assign stop  = queued;
  assign busy  = busy_reg;
  assign done  = done_reg;

`ifdef LINE_STATS_EN
  logic [SERVICE_W-1:0] served_reg;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      served_reg <= '0;
    end else if (done_next) begin
      served_reg <= served_reg + SERVICE_W'(1);
    end
  end

  assign served_cnt = served_reg;
`endif

endmodule

// File: tb/tb_line_grant_ctrl.sv
// Directed self-checking bench for line_grant_ctrl with SERVICE_FRAMES=3.
// Stats checks are compiled in only when LINE_STATS_EN is defined.
module tb_line_grant_ctrl;

  logic       Clk = 1'b0;
  logic       Reset_n;
  logic       frame_tick;
  logic [3:0] req;
  logic [3:0] grant;
  logic [3:0] stop;
  logic       busy;
  logic       done;
`ifdef LINE_STATS_EN
  logic [7:0] served_cnt;
`endif

  int checks = 0;
  int fails  = 0;

  always #5 Clk = ~Clk;

  line_grant_ctrl #(.SERVICE_FRAMES(3)) dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .frame_tick (frame_tick),
    .req        (req),
    .grant      (grant),
    .stop       (stop),
    .busy       (busy),
    .done       (done)
`ifdef LINE_STATS_EN
    ,
    .served_cnt (served_cnt)
`endif
  );

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic tick_pulse();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    Reset_n    = 1'b0;
    frame_tick = 1'b0;
    req        = 4'b0000;
    step();
    step();
    chk("reset_grant", 8'(grant), 8'h0);
    chk("reset_stop",  8'(stop),  8'h0);
    chk("reset_busy",  8'(busy),  8'h0);
    chk("reset_done",  8'(done),  8'h0);
    Reset_n = 1'b1;
    step();

    // Single child, three-frame grant
    req = 4'b0001;
    step();
    chk("t2_queued_stop",  8'(stop),  8'h1);
    chk("t2_queued_grant", 8'(grant), 8'h0);
    step();
    chk("t2_grant", 8'(grant), 8'h1);
    chk("t2_stop",  8'(stop),  8'h0);
    chk("t2_busy",  8'(busy),  8'h1);
    tick_pulse();
    tick_pulse();
    chk("t2_hold_grant", 8'(grant), 8'h1);
    tick_pulse();
    chk("t2_done",       8'(done),  8'h1);
    chk("t2_done_grant", 8'(grant), 8'h0);
    chk("t2_done_busy",  8'(busy),  8'h0);
    step();
    chk("t2_done_pulse", 8'(done), 8'h0);
    req = 4'b0000;
    step();

    // Two simultaneous rises, ascending order; tick during grant load ignored
    req = 4'b1010;
    step();
    chk("t3_stop_both", 8'(stop), 8'hA);
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    chk("t3_grant1", 8'(grant), 8'h2);
    chk("t3_stop3",  8'(stop),  8'h8);
    tick_pulse();
    tick_pulse();
    chk("t3_load_tick_ignored", 8'(grant), 8'h2);
    chk("t3_no_early_done",     8'(done),  8'h0);
    tick_pulse();
    chk("t3_done1", 8'(done),  8'h1);
    chk("t3_gap0",  8'(grant), 8'h0);
    step();
    chk("t3_gap1",  8'(grant), 8'h0);
    step();
    chk("t3_grant3",   8'(grant), 8'h8);
    chk("t3_stop_clr", 8'(stop),  8'h0);
    tick_pulse();
    tick_pulse();
    tick_pulse();
    chk("t3_done3", 8'(done), 8'h1);
    step();
    req = 4'b0000;
    step();

    // Queued child withdraws before reaching the head
    req = 4'b0001;
    step();
    step();
    chk("t4_grant0", 8'(grant), 8'h1);
    req = 4'b0101;
    step();
    chk("t4_stop2", 8'(stop), 8'h4);
    req = 4'b0001;
    step();
    chk("t4_stop2_held", 8'(stop), 8'h4);
    tick_pulse();
    tick_pulse();
    tick_pulse();
    chk("t4_done0", 8'(done), 8'h1);
    step();
    step();
    chk("t4_skip_stop",  8'(stop),  8'h0);
    chk("t4_skip_grant", 8'(grant), 8'h0);
    step();
    chk("t4_skip_busy",  8'(busy),  8'h0);
    chk("t4_skip_grant2", 8'(grant), 8'h0);
    req = 4'b0000;
    step();

    // Granted child drops request after one tick
    req = 4'b0010;
    step();
    step();
    chk("t5_grant", 8'(grant), 8'h2);
    tick_pulse();
    chk("t5_hold", 8'(grant), 8'h2);
    req = 4'b0000;
    step();
    chk("t5_done",  8'(done),  8'h1);
    chk("t5_grant_off", 8'(grant), 8'h0);
`ifdef LINE_STATS_EN
    chk("t5_served", served_cnt, 8'd5);
`endif
    step();

    // Asynchronous reset in the middle of a grant
    req = 4'b0001;
    step();
    req = 4'b0011;
    step();
    chk("t1_grant_pre", 8'(grant), 8'h1);
    chk("t1_stop_pre",  8'(stop),  8'h2);
    #3;
    Reset_n = 1'b0;
    #1;
    chk("t1_grant_async", 8'(grant), 8'h0);
    chk("t1_stop_async",  8'(stop),  8'h0);
    chk("t1_busy_async",  8'(busy),  8'h0);
    chk("t1_done_async",  8'(done),  8'h0);
    req = 4'b0000;
    step();
    chk("t1_no_done", 8'(done), 8'h0);
    Reset_n = 1'b1;
    step();
    step();
    chk("t1_idle_after", 8'(grant), 8'h0);
`ifdef LINE_STATS_EN
    chk("t1_served_clr", served_cnt, 8'd0);
`endif

`ifdef LINE_STATS_EN
    // 256 short grants wrap the served counter
    for (int k = 1; k <= 256; k++) begin
      req = 4'b0001;
      step();
      step();
      req = 4'b0000;
      step();
      if (k == 255) chk("t6_served_255", served_cnt, 8'd255);
      if (k == 256) chk("t6_served_wrap", served_cnt, 8'd0);
      step();
    end
`endif

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
